// File: rtl/display_pkg.sv
// display_pkg: active-low seven-segment constants and shared types for display paths.
package display_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'b1111;
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;
  function automatic logic [3:0] an_sel(input digit_t d);
    return ~(4'b0001 << d);
  endfunction
endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: digit/control inputs and scan outputs of the display scan controller.
// DISPLAY_BRIGHTNESS_PWM_EN adds the brightness input.
interface display_scan_ctrl_if;
  logic [15:0] digits;
  logic [3:0] dp_sel;
  logic lz_en;
  logic disp_en;
  logic [3:0] an;
  logic [6:0] sseg;
  logic dp;
  logic [1:0] digit_idx;
  logic frame_tick;
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
  logic [2:0] brightness;
`endif
  modport master(
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
    output brightness,
`endif
    output digits, dp_sel, lz_en, disp_en,
    input an, sseg, dp, digit_idx, frame_tick
  );
  modport slave(
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
    input brightness,
`endif
    input digits, dp_sel, lz_en, disp_en,
    output an, sseg, dp, digit_idx, frame_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex digit to active-low {g,f,e,d,c,b,a} segment decode.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);
  always_comb
    case (val)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed seven-segment scan with ghost guard and leading-zero blanking.
// DISPLAY_BRIGHTNESS_PWM_EN adds a 3-bit PWM brightness gate on the anodes.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W = 17
) (
  input logic clk,
  input logic reset,
  display_scan_ctrl_if.slave bus
);
  logic [CNT_W-1:0] cnt;
  digit_t idx, idx_nxt;
  logic [15:0] sh_digits;
  logic [3:0] sh_dp;
  logic sh_lz;
  logic slot_end, frame_end, blank_win, on, pwm_on;
  logic [3:0] cur, lz_blank, an_nxt;
  logic [6:0] dec, sseg_nxt;
  logic dp_nxt;
  assign slot_end = cnt == CNT_W'(SCAN_DIV - 1);
  assign frame_end = slot_end && idx == DIG3;
  assign blank_win = cnt < CNT_W'(BLANK_CYCLES);
  assign cur = 4'(sh_digits >> {idx, 2'b00});
  // a digit is blanked only while every digit to its left is blanked too
  assign lz_blank[3] = sh_lz && sh_digits[15:12] == 4'h0;
  assign lz_blank[2] = lz_blank[3] && sh_digits[11:8] == 4'h0;
  assign lz_blank[1] = lz_blank[2] && sh_digits[7:4] == 4'h0;
  assign lz_blank[0] = 1'b0;
  assign bus.digit_idx = idx;
  seg7_decode u_dec (.val(cur), .seg(dec));
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
  logic [2:0] pwm_cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) pwm_cnt <= '0;
    else pwm_cnt <= pwm_cnt + 3'd1;
  assign pwm_on = pwm_cnt <= bus.brightness;
`else
  assign pwm_on = 1'b1;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      idx <= DIG0;
      sh_digits <= '0;
      sh_dp <= '0;
      sh_lz <= 1'b0;
      bus.frame_tick <= 1'b0;
      bus.an <= AN_OFF;
      bus.sseg <= SEG_BLANK;
      bus.dp <= 1'b1;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      idx <= idx_nxt;
      bus.frame_tick <= frame_end;
      if (frame_end) begin
        sh_digits <= bus.digits;
        sh_dp <= bus.dp_sel;
        sh_lz <= bus.lz_en;
      end
      bus.an <= an_nxt;
      bus.sseg <= sseg_nxt;
      bus.dp <= dp_nxt;
    end
  always_comb idx_nxt = slot_end ? digit_t'(idx + 2'd1) : idx;
  always_comb begin
    on = !blank_win && bus.disp_en;
    an_nxt = on && pwm_on ? an_sel(idx) : AN_OFF;
    sseg_nxt = on ? (lz_blank[idx] ? SEG_BLANK : dec) : SEG_BLANK;
    dp_nxt = on ? ~sh_dp[idx] : 1'b1;
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: table vectors, corner sequences and randomized run against a cycle-count model.
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  display_scan_ctrl_if bus ();
  display_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYCLES(2), .CNT_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [6:0] seg_tab[16];
  int n;
  logic [15:0] sh_d;
  logic [3:0] sh_dp;
  logic sh_lz;
  logic [3:0] e_an;
  logic [6:0] e_sseg;
  logic e_dp, e_ft;
  logic [1:0] e_idx;
  typedef struct {
    logic [15:0] digits;
    logic [3:0] dp_sel;
    logic lz;
    logic [3:0][6:0] seg;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset;
    n = 0; sh_d = '0; sh_dp = '0; sh_lz = 1'b0;
    e_an = 4'hF; e_sseg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0; e_idx = 2'd0;
  endtask

  // expected outputs after the next edge, from the number of edges since reset
  task automatic model_step;
    int c, i;
    logic on, blk;
    logic [3:0] dg;
    c = n % 8;
    i = (n / 8) % 4;
    dg = sh_d[4*i +: 4];
    blk = sh_lz && i != 0 && (sh_d >> (4 * i)) == 16'h0;
    on = c >= 2 && bus.disp_en;
    e_sseg = on ? (blk ? 7'h7F : seg_tab[dg]) : 7'h7F;
    e_dp = on ? !sh_dp[i] : 1'b1;
    e_an = on ? 4'(~(4'b0001 << i)) : 4'hF;
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
    if (n % 8 > int'(bus.brightness)) e_an = 4'hF;
`endif
    e_ft = c == 7 && i == 3;
    if (e_ft) begin
      sh_d = bus.digits; sh_dp = bus.dp_sel; sh_lz = bus.lz_en;
    end
    n++;
    e_idx = 2'((n / 8) % 4);
  endtask

  task automatic run(input int k);
    repeat (k) begin
      model_step;
      @(posedge clk);
      #1;
      check("cycle{an,sseg,dp,idx,tick}", {bus.an, bus.sseg, bus.dp, bus.digit_idx, bus.frame_tick},
            {e_an, e_sseg, e_dp, e_idx, e_ft});
    end
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vt[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[1] = '{16'h5678, 4'b0100, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}};
    vt[2] = '{16'h0045, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h19, 7'h12}};
    vt[3] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vt[4] = '{16'hABCD, 4'b1111, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}};
    vt[5] = '{16'h0E90, 4'b0001, 1'b1, {7'h7F, 7'h06, 7'h10, 7'h40}};
    vt[6] = '{16'h00F0, 4'b1010, 1'b0, {7'h40, 7'h40, 7'h0E, 7'h40}};
    bus.digits = 16'h1234; bus.dp_sel = 4'b0000; bus.lz_en = 1'b0; bus.disp_en = 1'b1;
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
    bus.brightness = 3'd7;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {bus.an, bus.sseg, bus.dp, bus.digit_idx, bus.frame_tick}, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    model_reset;
    run(2);
    check("first_blank_an", bus.an, 4'hF);
    run(1);
    check("first_zero_an", bus.an, 4'b1110);
    check("first_zero_sseg", bus.sseg, 7'h40);
    run(29);
    check("frame_tick", bus.frame_tick, 1'b1);
    run(3);
    check("d0_shows_4", {bus.an, bus.sseg}, {4'b1110, 7'h19});
    run(5);
    run(3);
    check("d1_shows_3", {bus.an, bus.sseg}, {4'b1101, 7'h30});
    bus.digits = 16'h5678;
    run(5);
    run(3);
    check("d2_no_tear", {bus.an, bus.sseg}, {4'b1011, 7'h24});
    run(13);
    run(3);
    check("next_frame_8", {bus.an, bus.sseg}, {4'b1110, 7'h00});
    run(5);
    for (int v = 0; v < 7; v++) begin
      bus.digits = vt[v].digits; bus.dp_sel = vt[v].dp_sel; bus.lz_en = vt[v].lz;
      run(1);
      for (int w = 0; w < 32 && n % 32 != 0; w++) run(1);
      for (int s = 0; s < 4; s++) begin
        run(3);
        check("tbl_an", bus.an, 4'(~(4'b0001 << s)));
        check("tbl_sseg", bus.sseg, vt[v].seg[s]);
        check("tbl_dp", bus.dp, !vt[v].dp_sel[s]);
        run(5);
      end
    end
    run(4);
    bus.disp_en = 1'b0;
    run(1);
    check("disp_off_an", {bus.an, bus.sseg, bus.dp}, {4'hF, 7'h7F, 1'b1});
    run(8);
    check("disp_off_idx_runs", bus.digit_idx, 2'd1);
    bus.disp_en = 1'b1;
    run(3);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", {bus.an, bus.sseg, bus.dp, bus.digit_idx}, {4'hF, 7'h7F, 1'b1, 2'd0});
    @(negedge clk);
    reset = 1'b0;
    model_reset;
    run(3);
    check("post_reset_zero", {bus.an, bus.sseg}, {4'b1110, 7'h40});
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
    bus.brightness = 3'd3;
    run(5);
    begin
      int lit = 0;
      for (int k = 0; k < 8; k++) begin
        run(1);
        if (bus.an != 4'hF) lit++;
      end
      check("pwm_lit_cycles", lit, 2);
    end
`endif
    repeat (300) begin
      if ($urandom_range(3) == 0) begin
        bus.digits = 16'($urandom);
        bus.dp_sel = 4'($urandom);
        bus.lz_en = 1'($urandom);
        bus.disp_en = $urandom_range(4) != 0;
`ifdef DISPLAY_BRIGHTNESS_PWM_EN
        bus.brightness = 3'($urandom);
`endif
      end
      run(1 + $urandom_range(4));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
